// File: rtl/phase_extract_pkg.sv
// Shared types and helpers for the phase-extraction datapath.
// Contents:
//   seq_state_t     - run sequencer state encoding
//   sample_t        - signed antenna sample (SAMPLE_W bits)
//   bin_addr_t      - FFT frame buffer / bin address (BIN_ADDR_W bits)
//   frame_len()     - frame length for a given FFT depth
//   run_idx_width() - width of a run index covering 0..runs-1
package phase_extract_pkg;

    localparam int unsigned SAMPLE_W   = 14;
    localparam int unsigned BIN_ADDR_W = 11;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [BIN_ADDR_W-1:0]      bin_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        KICK,
        FFT_WAIT,
        NEXT,
        FINISH
    } seq_state_t;

    function automatic int unsigned frame_len(input int unsigned depth);
        return 32'd1 << depth;
    endfunction

    function automatic int unsigned run_idx_width(input int unsigned runs);
        return $clog2(runs + 1);
    endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Frame address counter shared by the capture and FFT readout paths.
// Ports:
//   clk, reset_n - clock, synchronous active-low reset
//   en           - advance the count by one
//   clr          - return the count to zero (wins over en)
//   count        - current address
//   wrap_c       - combinational: high when en is set on the last address
module frame_addr_counter #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap_c
);

    assign wrap_c = en && (count == {WIDTH{1'b1}});

    // Natural binary wrap takes the last address back to 0.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fft_run_sequencer.sv
// Sequences RUNS frames of capture -> FFT start -> FFT completion.
// Optional feature: define PHASE_EXTRACT_FFT_TIMEOUT_EN to abandon a frame
// (error set, no done) after TIMEOUT_CYCLES cycles in FFT_WAIT.
// Ports:
//   clk, reset_n            - clock, synchronous active-low reset
//   start, abort            - measurement request / cancel strobes
//   sample_valid/data       - synchronised antenna sample strobe and value
//   buf_wr_en/addr/data     - frame buffer write port (registered)
//   fft_start, fft_done     - FFT core handshake pulses
//   run_idx, busy, done     - status to control logic (registered)
//   error                   - sticky overrun/timeout flag, cleared by start
module fft_run_sequencer
    import phase_extract_pkg::*;
#(
    parameter int unsigned SINK_WIDTH     = 14,
    parameter int unsigned FFT_DEPTH      = 11,
    parameter int unsigned RUNS           = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            sample_valid,
    input  logic [SINK_WIDTH-1:0]           sample_data,
    output logic                            buf_wr_en,
    output logic [FFT_DEPTH-1:0]            buf_wr_addr,
    output logic [SINK_WIDTH-1:0]           buf_wr_data,
    output logic                            fft_start,
    input  logic                            fft_done,
    output logic [run_idx_width(RUNS)-1:0]  run_idx,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam int unsigned RUN_W = run_idx_width(RUNS);

    if (RUNS < 1) begin : g_runs_check
        $error("fft_run_sequencer: RUNS must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("fft_run_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_t           state, state_d;
    logic [RUN_W-1:0]     run_idx_d;
    logic                 error_d, busy_d, done_d, fft_start_d;
    logic                 start_take_c, wr_take_c, overrun_c, timeout_c, wrap_c;
    logic [FFT_DEPTH-1:0] count;

    // A write happens only for a strobe in CAPTURE that is not cancelled.
    assign wr_take_c = (state == CAPTURE) && sample_valid && !abort;
    assign overrun_c = sample_valid && !abort &&
                       ((state == KICK) || (state == FFT_WAIT) ||
                        (state == NEXT) || (state == FINISH));

    frame_addr_counter #(
        .WIDTH (FFT_DEPTH)
    ) u_addr_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (wr_take_c),
        .clr     (start_take_c | abort),
        .count   (count),
        .wrap_c  (wrap_c)
    );

`ifdef PHASE_EXTRACT_FFT_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr;

    // Counts cycles spent in FFT_WAIT; zero on every entry.
    always_ff @(posedge clk) begin
        if (!reset_n || (state != FFT_WAIT)) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    assign timeout_c = (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and next-output decode; abort overrides every transition.
    always_comb begin
        state_d      = state;
        run_idx_d    = run_idx;
        error_d      = error;
        start_take_c = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_d      = CAPTURE;
                        start_take_c = 1'b1;
                        error_d      = 1'b0;
                        run_idx_d    = '0;
                    end
                end
                CAPTURE: begin
                    if (wrap_c) state_d = KICK;
                end
                KICK: state_d = FFT_WAIT;
                FFT_WAIT: begin
                    if (fft_done) begin
                        state_d = NEXT;
                    end else if (timeout_c) begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end
                end
                NEXT: begin
                    if (run_idx == RUN_W'(RUNS - 1)) begin
                        state_d = FINISH;
                    end else begin
                        state_d   = CAPTURE;
                        run_idx_d = run_idx + RUN_W'(1);
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (overrun_c) error_d = 1'b1;
        end
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FINISH);
        fft_start_d = (state_d == KICK);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Registered outputs, aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            fft_start   <= 1'b0;
            run_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            buf_wr_en <= wr_take_c;
            if (wr_take_c) begin
                buf_wr_addr <= count;
                buf_wr_data <= sample_data;
            end
            fft_start <= fft_start_d;
            run_idx   <= run_idx_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_fft_run_sequencer.sv
// Directed bench for fft_run_sequencer with FFT_DEPTH=3, RUNS=3.
module tb_fft_run_sequencer;

    localparam int unsigned SW  = 14;
    localparam int unsigned FD  = 3;
    localparam int unsigned RN  = 3;
    localparam int unsigned TO  = 10;

    logic          clk = 1'b0;
    logic          reset_n, start, abort, sample_valid, fft_done;
    logic [SW-1:0] sample_data;
    logic          buf_wr_en, fft_start, busy, done, error;
    logic [FD-1:0] buf_wr_addr;
    logic [SW-1:0] buf_wr_data;
    logic [1:0]    run_idx;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0, fs_cnt = 0, done_cnt = 0;

    fft_run_sequencer #(
        .SINK_WIDTH     (SW),
        .FFT_DEPTH      (FD),
        .RUNS           (RN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .buf_wr_en    (buf_wr_en),
        .buf_wr_addr  (buf_wr_addr),
        .buf_wr_data  (buf_wr_data),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .run_idx      (run_idx),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (buf_wr_en) wr_cnt   <= wr_cnt + 1;
        if (fft_start) fs_cnt   <= fs_cnt + 1;
        if (done)      done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [SW-1:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        step();
        sample_valid = 1'b0;
        step();
    endtask

    task automatic capture_frame(input int base);
        for (int i = 0; i < 8; i++) strobe(14'(base + i));
    endtask

    task automatic fft_reply();
        repeat (3) step();
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++; if ({busy, done, error, fft_start, buf_wr_en} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {busy, done, error, fft_start, buf_wr_en});
        end
        checks++; if (buf_wr_addr !== 3'd0) begin
            errors++; $display("FAIL reset_addr: got %0d want 0", buf_wr_addr);
        end
        checks++; if (buf_wr_data !== 14'd0) begin
            errors++; $display("FAIL reset_data: got %0h want 0", buf_wr_data);
        end
        checks++; if (run_idx !== 2'd0) begin
            errors++; $display("FAIL reset_run_idx: got %0d want 0", run_idx);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_nominal();
        int f0, d0, w0;
        logic [SW-1:0] d;
        logic exp_fs;
        f0 = fs_cnt; d0 = done_cnt; w0 = wr_cnt;
        do_start();
        checks++; if (busy !== 1'b1 || run_idx !== 2'd0 || error !== 1'b0) begin
            errors++; $display("FAIL nom_start: got busy=%b run=%0d err=%b want 1/0/0", busy, run_idx, error);
        end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                d = 14'(r * 40 - 60 + i * 9);
                exp_fs = (i == 7);
                sample_valid = 1'b1;
                sample_data  = d;
                step();
                sample_valid = 1'b0;
                checks++; if (buf_wr_en !== 1'b1 || buf_wr_addr !== 3'(i)) begin
                    errors++; $display("FAIL nom_wr r%0d i%0d: got en=%b addr=%0d want 1/%0d", r, i, buf_wr_en, buf_wr_addr, i);
                end
                checks++; if (buf_wr_data !== d) begin
                    errors++; $display("FAIL nom_data r%0d i%0d: got %0h want %0h", r, i, buf_wr_data, d);
                end
                checks++; if (run_idx !== 2'(r) || busy !== 1'b1) begin
                    errors++; $display("FAIL nom_status r%0d i%0d: got run=%0d busy=%b want %0d/1", r, i, run_idx, busy, r);
                end
                checks++; if (fft_start !== exp_fs) begin
                    errors++; $display("FAIL nom_fft_start r%0d i%0d: got %b want %b", r, i, fft_start, exp_fs);
                end
                step();
                checks++; if (buf_wr_en !== 1'b0) begin
                    errors++; $display("FAIL nom_wr_gap r%0d i%0d: got %b want 0", r, i, buf_wr_en);
                end
            end
            repeat (3) step();
            checks++; if (fft_start !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL nom_wait r%0d: got fs=%b busy=%b want 0/1", r, fft_start, busy);
            end
            fft_done = 1'b1;
            step();
            fft_done = 1'b0;
            step();
            if (r < 2) begin
                checks++; if (run_idx !== 2'(r + 1) || busy !== 1'b1 || done !== 1'b0) begin
                    errors++; $display("FAIL nom_next r%0d: got run=%0d busy=%b done=%b want %0d/1/0", r, run_idx, busy, done, r + 1);
                end
            end else begin
                checks++; if (done !== 1'b1 || run_idx !== 2'd2 || busy !== 1'b1) begin
                    errors++; $display("FAIL nom_finish: got done=%b run=%0d busy=%b want 1/2/1", done, run_idx, busy);
                end
            end
        end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || run_idx !== 2'd2) begin
            errors++; $display("FAIL nom_idle: got done=%b busy=%b run=%0d want 0/0/2", done, busy, run_idx);
        end
        checks++; if (fs_cnt - f0 != 3 || done_cnt - d0 != 1 || wr_cnt - w0 != 24) begin
            errors++; $display("FAIL nom_counts: got fs=%0d done=%0d wr=%0d want 3/1/24", fs_cnt - f0, done_cnt - d0, wr_cnt - w0);
        end
        checks++; if (error !== 1'b0) begin
            errors++; $display("FAIL nom_error: got %b want 0", error);
        end
    endtask

    task automatic test_done_in_kick();
        do_start();
        for (int i = 0; i < 7; i++) strobe(14'(i));
        sample_valid = 1'b1;
        sample_data  = 14'h0077;
        step();
        sample_valid = 1'b0;
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        repeat (3) step();
        checks++; if (run_idx !== 2'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL kick_done_ignored: got run=%0d busy=%b want 0/1", run_idx, busy);
        end
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        step();
        checks++; if (run_idx !== 2'd1) begin
            errors++; $display("FAIL kick_done_later: got run=%0d want 1", run_idx);
        end
        do_abort();
    endtask

    task automatic test_overrun();
        int d0, w0;
        d0 = done_cnt; w0 = wr_cnt;
        do_start();
        capture_frame(100);
        sample_valid = 1'b1;
        sample_data  = 14'h1555;
        step();
        sample_valid = 1'b0;
        checks++; if (buf_wr_en !== 1'b0 || error !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL ovr_flag: got en=%b err=%b busy=%b want 0/1/1", buf_wr_en, error, busy);
        end
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        step();
        checks++; if (run_idx !== 2'd1) begin
            errors++; $display("FAIL ovr_run1: got %0d want 1", run_idx);
        end
        capture_frame(200);
        fft_reply();
        capture_frame(300);
        fft_reply();
        checks++; if (done !== 1'b1) begin
            errors++; $display("FAIL ovr_done: got %b want 1", done);
        end
        step();
        checks++; if (busy !== 1'b0 || done_cnt - d0 != 1 || wr_cnt - w0 != 24 || error !== 1'b1) begin
            errors++; $display("FAIL ovr_end: got busy=%b done_cnt=%0d wr=%0d err=%b want 0/1/24/1", busy, done_cnt - d0, wr_cnt - w0, error);
        end
    endtask

    task automatic test_abort();
        int f0, d0;
        do_start();
        checks++; if (error !== 1'b0) begin
            errors++; $display("FAIL abort_err_clear: got %b want 0", error);
        end
        f0 = fs_cnt; d0 = done_cnt;
        capture_frame(0);
        fft_reply();
        for (int i = 0; i < 5; i++) strobe(14'(50 + i));
        abort        = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 14'h0999;
        step();
        abort        = 1'b0;
        sample_valid = 1'b0;
        checks++; if ({busy, buf_wr_en, fft_start, done, error} !== 5'b0) begin
            errors++; $display("FAIL abort_idle: got busy/en/fs/done/err=%b want 00000", {busy, buf_wr_en, fft_start, done, error});
        end
        repeat (4) step();
        checks++; if (fs_cnt - f0 != 1 || done_cnt - d0 != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_quiet: got fs=%0d done=%0d busy=%b want 1/0/0", fs_cnt - f0, done_cnt - d0, busy);
        end
        do_start();
        sample_valid = 1'b1;
        sample_data  = 14'h1ABC;
        step();
        sample_valid = 1'b0;
        checks++; if (buf_wr_en !== 1'b1 || buf_wr_addr !== 3'd0 || run_idx !== 2'd0) begin
            errors++; $display("FAIL abort_restart: got en=%b addr=%0d run=%0d want 1/0/0", buf_wr_en, buf_wr_addr, run_idx);
        end
        step();
        do_abort();
    endtask

    task automatic test_start_busy();
        do_start();
        for (int i = 0; i < 3; i++) strobe(14'(i));
        do_start();
        checks++; if (busy !== 1'b1 || run_idx !== 2'd0) begin
            errors++; $display("FAIL sbusy_status: got busy=%b run=%0d want 1/0", busy, run_idx);
        end
        sample_valid = 1'b1;
        sample_data  = 14'h0033;
        step();
        sample_valid = 1'b0;
        checks++; if (buf_wr_en !== 1'b1 || buf_wr_addr !== 3'd3 || run_idx !== 2'd0) begin
            errors++; $display("FAIL sbusy_addr: got en=%b addr=%0d run=%0d want 1/3/0", buf_wr_en, buf_wr_addr, run_idx);
        end
        step();
        do_abort();
    endtask

    task automatic test_reset_mid();
        do_start();
        for (int i = 0; i < 4; i++) strobe(14'(10 + i));
        sample_valid = 1'b1;
        sample_data  = 14'h0444;
        reset_n      = 1'b0;
        step();
        sample_valid = 1'b0;
        reset_n      = 1'b1;
        checks++; if ({busy, buf_wr_en, fft_start, done, error} !== 5'b0 || run_idx !== 2'd0) begin
            errors++; $display("FAIL rmid_flags: got %b run=%0d want 00000/0", {busy, buf_wr_en, fft_start, done, error}, run_idx);
        end
        checks++; if (buf_wr_addr !== 3'd0 || buf_wr_data !== 14'd0) begin
            errors++; $display("FAIL rmid_bus: got addr=%0d data=%0h want 0/0", buf_wr_addr, buf_wr_data);
        end
        sample_valid = 1'b1;
        sample_data  = 14'h0555;
        step();
        sample_valid = 1'b0;
        checks++; if (busy !== 1'b0 || buf_wr_en !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL rmid_idle_ignore: got busy=%b en=%b err=%b want 0/0/0", busy, buf_wr_en, error);
        end
        do_start();
        sample_valid = 1'b1;
        sample_data  = 14'h0666;
        step();
        sample_valid = 1'b0;
        checks++; if (buf_wr_en !== 1'b1 || buf_wr_addr !== 3'd0) begin
            errors++; $display("FAIL rmid_restart: got en=%b addr=%0d want 1/0", buf_wr_en, buf_wr_addr);
        end
        step();
        do_abort();
    endtask

`ifdef PHASE_EXTRACT_FFT_TIMEOUT_EN
    task automatic test_timeout();
        int d0;
        d0 = done_cnt;
        do_start();
        capture_frame(500);
        repeat (9) step();
        checks++; if (busy !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL tmo_before: got busy=%b err=%b want 1/0", busy, error);
        end
        step();
        checks++; if (busy !== 1'b0 || error !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL tmo_expire: got busy=%b err=%b done=%b want 0/1/0", busy, error, done);
        end
        step();
        checks++; if (done_cnt != d0) begin
            errors++; $display("FAIL tmo_no_done: got %0d done pulses want 0", done_cnt - d0);
        end
    endtask
`endif

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        fft_done     = 1'b0;
        test_reset();
        test_nominal();
        test_done_in_kick();
        test_overrun();
        test_abort();
        test_start_busy();
        test_reset_mid();
`ifdef PHASE_EXTRACT_FFT_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_run_sequencer.md
Name: fft_run_sequencer

Overview:
- Sequences the phase-extraction datapath for one measurement of RUNS consecutive frames.
- Per frame: captures 2**FFT_DEPTH antenna samples into the FFT frame buffer, starts the FFT core, and waits for its completion.
- Sits between the clk20-domain sample synchroniser (which delivers one-cycle strobes in the clk domain) and the FFT core/buffer.
- Reports run index, busy and done status to the control logic.

Parameters:
- SINK_WIDTH, 14, bits per antenna sample
- FFT_DEPTH, 11, FFT levels; frame length N = 2**FFT_DEPTH
- RUNS, 3, frames per measurement (>=1)
- TIMEOUT_CYCLES, 65535, clk cycles allowed in FFT_WAIT (used only with the optional feature)

Ports:
- clk  in  1  main clock (50 MHz)
- reset_n  in  1  synchronous reset, active low
- start  in  1  one-cycle request to begin a measurement
- abort  in  1  one-cycle request to cancel the current measurement
- sample_valid  in  1  one-cycle strobe: sample_data holds a new sample
- sample_data  in  SINK_WIDTH  antenna sample (two's complement)
- buf_wr_en  out  1  frame buffer write enable
- buf_wr_addr  out  FFT_DEPTH  frame buffer write address
- buf_wr_data  out  SINK_WIDTH  frame buffer write data
- fft_start  out  1  one-cycle pulse to start the FFT core
- fft_done  in  1  one-cycle pulse from the FFT core
- run_idx  out  $clog2(RUNS+1)  index of the current frame, 0..RUNS-1
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the measurement completes
- error  out  1  sticky error flag; cleared by reset or start

Behaviour:
- Clocking and reset
  - All logic is on the rising edge of clk.
  - reset_n=0 forces state IDLE.
  - Reset values: every output is 0, buf_wr_addr=0, run_idx=0, sample counter=0.
- States: IDLE, CAPTURE, KICK, FFT_WAIT, NEXT, FINISH.
- IDLE
  - start=1 → CAPTURE; clears error, run_idx and the sample counter.
  - sample_valid is ignored.
- CAPTURE
  - Each sample_valid registers buf_wr_en=1, buf_wr_addr=counter and buf_wr_data=sample_data on the next edge; latency is 1 cycle.
  - The counter increments on each write. On write N-1 the counter wraps to 0 and the state goes to KICK.
- KICK
  - fft_start=1 for exactly one cycle, then → FFT_WAIT.
  - A sample_valid arriving in KICK, FFT_WAIT, NEXT or FINISH is dropped and sets error (overrun).
- FFT_WAIT
  - fft_done=1 → NEXT.
  - fft_done in any other state is ignored.
- NEXT
  - If run_idx==RUNS-1 → FINISH.
  - Otherwise run_idx increments and the state goes to CAPTURE.
- FINISH
  - done=1 for one cycle, then → IDLE.
  - run_idx holds its last value until the next start.
- busy is a registered decode of state != IDLE.
- start while busy is ignored.
- abort has priority over every transition except reset.
  - On abort: → IDLE next cycle, buf_wr_en and fft_start drop, no done pulse, error unchanged.
- Simultaneous sample_valid and abort in CAPTURE: no write occurs.
- fft_done arriving in the same cycle as fft_start is not accepted; acceptance starts from the first FFT_WAIT cycle.
- RUNS=1: NEXT goes directly to FINISH.
- Reset asserted mid-frame: the buffer write is abandoned and the counter returns to 0.

Optional Feature:
- Macro: PHASE_EXTRACT_FFT_TIMEOUT_EN
- Defined:
  - A counter runs in FFT_WAIT.
  - If TIMEOUT_CYCLES elapse without fft_done, error is set and the state goes to IDLE with no done pulse.
  - The counter clears on entry to FFT_WAIT.
- Undefined: no counter; FFT_WAIT waits indefinitely, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package phase_extract_pkg holds:
  - the state enum type seq_state_t
  - localparam-style functions for frame length (2**FFT_DEPTH) and run-index width
  - shared typedefs sample_t (signed [SINK_WIDTH-1:0]) and bin_addr_t ([FFT_DEPTH-1:0]), which are reused by the FFT core and buffer.
- Sub-module frame_addr_counter (FFT_DEPTH-wide, with enable, clear and a wrap pulse) is natural. The same counter serves the FFT readout side.

Test Plan:
- Nominal, FFT_DEPTH=3, RUNS=3:
  - Stimulus: start, 24 strobes spaced 2 cycles, fft_done 5 cycles after each fft_start.
  - Required: 3 fft_start pulses, addresses 0..7 written three times, run_idx 0→1→2, one done pulse, busy high throughout, error=0.
- Overrun:
  - Stimulus: sample_valid during FFT_WAIT.
  - Required: no buf_wr_en, error=1, and the sequence still completes with done.
- Abort:
  - Stimulus: abort after the 5th sample of run 1.
  - Required: IDLE on the next cycle, no fft_start, no done, busy=0.
  - Then a new start writes address 0 first with run_idx=0.
- Start while busy:
  - Stimulus: a second start in CAPTURE.
  - Required: ignored; counter and run_idx unaffected.
- Reset mid-capture:
  - Stimulus: reset_n low for 1 cycle at sample 4.
  - Required: all outputs 0 on the next edge; state IDLE.
- Timeout (macro defined, TIMEOUT_CYCLES=10):
  - Stimulus: no fft_done.
  - Required: error=1 and IDLE after 10 FFT_WAIT cycles; no done.
